codec_output_scheduler: RTL and testbench

Sits between music_player and adau1761_codec. Buffers samples from music_player in a small FIFO and releases exactly one sample per codec new_frame. Routes each sample to the headphone channels according to a channel mode. Ramps gain down and back up around mode changes and enable changes, so routing switches without clicks.

---
 rtl/codec_output_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_codec_output_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_output_scheduler.sv
// Output scheduler between music_player and the ADAU1761 codec: frame-paced FIFO drain,
// headphone channel routing and click-free gain ramps around mode/enable changes.
module codec_output_scheduler #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int RAMP_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic [15:0]     sample_in,
    input  logic            sample_valid,
    input  logic            new_frame,
    input  logic            clear_flags,
    output logic [23:0]     hphone_l,
    output logic [23:0]     hphone_r,
    output logic [ADDR_W:0] fifo_level,
    output logic            underrun,
    output logic            overrun,
    output logic [1:0]      state
);

    localparam logic [1:0] S_IDLE     = 2'b00;
    localparam logic [1:0] S_FADE_IN  = 2'b01;
    localparam logic [1:0] S_RUN      = 2'b10;
    localparam logic [1:0] S_FADE_OUT = 2'b11;

    localparam logic [1:0] M_MONO  = 2'b00;
    localparam logic [1:0] M_LEFT  = 2'b01;
    localparam logic [1:0] M_RIGHT = 2'b10;
    localparam logic [1:0] M_PING  = 2'b11;

    localparam logic [4:0]      GAIN_UNITY = 5'd16;
    localparam logic [4:0]      STEP5      = 5'(RAMP_STEP);
    localparam logic [5:0]      STEP6      = 6'(RAMP_STEP);
    localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W + 1)'(1);

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [4:0]        gain;
    logic [1:0]        active_mode;
    logic              toggle;

    logic              active;
    logic              empty;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              push_drop;
    logic              frame_empty;
    logic              exit_req;
    logic [15:0]       popped;
    logic signed [20:0] s_ext;
    logic signed [20:0] g_ext;
    logic signed [20:0] product;
    logic [15:0]       scaled;
    logic [23:0]       word;
    logic [23:0]       next_l;
    logic [23:0]       next_r;
    logic [5:0]        gain_sum;
    logic [4:0]        gain_up;
    logic [4:0]        gain_dn;

    always_comb begin
        active      = (state != S_IDLE);
        fifo_level  = wr_ptr - rd_ptr;
        empty       = (fifo_level == '0);
        full        = (fifo_level == LEVEL_FULL);
        pop         = active && new_frame && !empty;
        // a same-cycle pop frees the slot, so a push into a full FIFO still lands
        push_ok     = active && sample_valid && (!full || pop);
        push_drop   = active && sample_valid && full && !pop;
        frame_empty = active && new_frame && empty;
        exit_req    = !enable || (mode != active_mode);
    end

    always_comb begin
        popped  = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];
        s_ext   = {{5{popped[15]}}, popped};
        g_ext   = {16'd0, gain};
        product = s_ext * g_ext;
        scaled  = 16'(product >>> 4);
        word    = {scaled, 8'h00};
        next_l  = '0;
        next_r  = '0;
        case (active_mode)
            M_MONO: begin
                next_l = word;
                next_r = word;
            end
            M_LEFT:  next_l = word;
            M_RIGHT: next_r = word;
            M_PING: begin
                if (toggle) next_r = word;
                else        next_l = word;
            end
            default: ;
        endcase
    end

    always_comb begin
        gain_sum = {1'b0, gain} + STEP6;
        gain_up  = (gain_sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : gain_sum[4:0];
        gain_dn  = (gain > STEP5) ? (gain - STEP5) : '0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= sample_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (!active) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            gain        <= '0;
            active_mode <= M_MONO;
            toggle      <= 1'b0;
        end else begin
            if (active && new_frame) toggle <= ~toggle;
            case (state)
                S_IDLE: begin
                    if (new_frame && enable) begin
                        state       <= S_FADE_IN;
                        gain        <= '0;
                        active_mode <= mode;
                        toggle      <= 1'b0;
                    end
                end
                S_FADE_IN: begin
                    if (exit_req) begin
                        state <= S_FADE_OUT;
                    end else if (new_frame) begin
                        gain <= gain_up;
                        if (gain_up == GAIN_UNITY) state <= S_RUN;
                    end
                end
                S_RUN: begin
                    gain <= GAIN_UNITY;
                    if (exit_req) state <= S_FADE_OUT;
                end
                S_FADE_OUT: begin
                    if (new_frame) begin
                        // the zero-gain frame is emitted before leaving the fade
                        if (gain == '0) begin
                            toggle <= 1'b0;
                            if (!enable) begin
                                state <= S_IDLE;
                            end else begin
                                active_mode <= mode;
                                state       <= S_FADE_IN;
                            end
                        end else begin
                            gain <= gain_dn;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hphone_l <= '0;
            hphone_r <= '0;
        end else if (new_frame) begin
            hphone_l <= active ? next_l : '0;
            hphone_r <= active ? next_r : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            underrun <= frame_empty || (underrun && !clear_flags);
            overrun  <= push_drop || (overrun && !clear_flags);
        end
    end

endmodule

// File: tb/tb_codec_output_scheduler.sv
// Bench for codec_output_scheduler: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_codec_output_scheduler;

    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 3;
    localparam int RAMP_STEP = 1;
    localparam int IDLE = 0, FADE_IN = 1, RUN = 2, FADE_OUT = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [1:0]      mode;
    logic [15:0]     sample_in;
    logic            sample_valid;
    logic            new_frame;
    logic            clear_flags;
    logic [23:0]     hphone_l;
    logic [23:0]     hphone_r;
    logic [ADDR_W:0] fifo_level;
    logic            underrun;
    logic            overrun;
    logic [1:0]      state;

    codec_output_scheduler #(
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .RAMP_STEP(RAMP_STEP)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .mode(mode),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .new_frame(new_frame),
        .clear_flags(clear_flags),
        .hphone_l(hphone_l),
        .hphone_r(hphone_r),
        .fifo_level(fifo_level),
        .underrun(underrun),
        .overrun(overrun),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_state, m_gain, m_mode, m_tog;
    logic [15:0] m_q[$];
    logic [23:0] m_l, m_r;
    bit          m_under, m_over;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] scale_word(input logic [15:0] s, input int g);
        int p;
        p = $signed(s) * g;
        p = p >>> 4;
        return {p[15:0], 8'h00};
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_gain = 0; m_mode = 0; m_tog = 0;
        m_q.delete();
        m_l = '0; m_r = '0; m_under = 0; m_over = 0;
    endtask

    task automatic model_step(input bit sv, input logic [15:0] sin, input bit nf, input bit clr);
        bit          und, ovr, left_on, right_on;
        logic [15:0] s;
        logic [23:0] w;
        und = 0; ovr = 0; s = '0;
        if (m_state == IDLE) begin
            m_q.delete();
            if (nf) begin
                m_l = '0; m_r = '0;
                if (enable) begin
                    m_state = FADE_IN; m_gain = 0; m_mode = int'(mode); m_tog = 0;
                end
            end
        end else begin
            if (nf) begin
                if (m_q.size() > 0) s = m_q.pop_front();
                else und = 1;
            end
            if (sv) begin
                if (m_q.size() < DEPTH) m_q.push_back(sin);
                else ovr = 1;
            end
            if (nf) begin
                w        = scale_word(s, m_gain);
                left_on  = (m_mode == 0) || (m_mode == 1) || (m_mode == 3 && m_tog == 0);
                right_on = (m_mode == 0) || (m_mode == 2) || (m_mode == 3 && m_tog == 1);
                m_l      = left_on  ? w : 24'h0;
                m_r      = right_on ? w : 24'h0;
                m_tog    = 1 - m_tog;
            end
            case (m_state)
                FADE_IN: begin
                    if (!enable || int'(mode) != m_mode) m_state = FADE_OUT;
                    else if (nf) begin
                        m_gain = (m_gain + RAMP_STEP > 16) ? 16 : m_gain + RAMP_STEP;
                        if (m_gain == 16) m_state = RUN;
                    end
                end
                RUN: if (!enable || int'(mode) != m_mode) m_state = FADE_OUT;
                FADE_OUT: begin
                    if (nf) begin
                        if (m_gain == 0) begin
                            if (!enable) m_state = IDLE;
                            else begin
                                m_mode = int'(mode); m_tog = 0; m_state = FADE_IN;
                            end
                        end else begin
                            m_gain = (m_gain < RAMP_STEP) ? 0 : m_gain - RAMP_STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_under = und || (m_under && !clr);
        m_over  = ovr || (m_over && !clr);
    endtask

    task automatic compare_all();
        check("hphone_l", hphone_l, m_l);
        check("hphone_r", hphone_r, m_r);
        check("fifo_level", fifo_level, m_q.size());
        check("underrun", underrun, m_under);
        check("overrun", overrun, m_over);
        check("state", state, m_state);
    endtask

    task automatic cyc(input bit sv, input logic [15:0] sin, input bit nf, input bit clr);
        sample_valid = sv; sample_in = sin; new_frame = nf; clear_flags = clr;
        model_step(sv, sin, nf, clr);
        @(posedge clk);
        #1;
        sample_valid = 0; new_frame = 0; clear_flags = 0;
        compare_all();
    endtask

    task automatic frame(input logic [15:0] s);
        cyc(1, s, 0, 0);
        cyc(0, 16'h0, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; enable = 0; mode = 2'b00;
        sample_valid = 0; sample_in = '0; new_frame = 0; clear_flags = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_l", hphone_l, 0);
        check("rst_level", fifo_level, 0);
        reset_n = 1;
        compare_all();

        // fade-in from IDLE at mono
        enable = 1; mode = 2'b00;
        frame(16'h4000);
        for (int k = 0; k <= 16; k++) begin
            frame(16'h4000);
            if (k == 8) check("t1_gain8_l", hphone_l, 24'h200000);
        end
        check("t1_run_state", state, RUN);
        check("t1_run_r", hphone_r, 24'h400000);

        // signed scaling: unity on full-scale negative, then gain 1 while fading out
        frame(16'h8000);
        check("t2_unity_neg", hphone_l, 24'h800000);
        enable = 0;
        for (int j = 0; j < 16; j++) frame(16'h8000);
        check("t2_gain1_l", hphone_l, 24'hF80000);
        check("t2_gain1_r", hphone_r, 24'hF80000);
        frame(16'h8000);
        check("t2_idle", state, IDLE);

        // mode switch 00 -> 01 from RUN
        enable = 1;
        for (int j = 0; j < 17; j++) frame(16'h4000);
        check("t3_run", state, RUN);
        mode = 2'b01;
        for (int j = 0; j < 16; j++) begin
            frame(16'h4000);
            check("t3_fade_mono", hphone_r, hphone_l);
        end
        frame(16'h4000);
        check("t3_zero_l", hphone_l, 0);
        check("t3_refade", state, FADE_IN);
        for (int k = 0; k <= 16; k++) begin
            frame(16'h4000);
            check("t3_r_silent", hphone_r, 0);
        end
        check("t3_left_only", hphone_l, 24'h400000);

        // ping-pong
        mode = 2'b11;
        for (int j = 0; j < 17; j++) frame(16'h1000);
        check("t4_fade_in", state, FADE_IN);
        for (int k = 0; k < 20; k++) begin
            frame(16'h1000);
            if (k >= 16) begin
                check("t4_pp_l", hphone_l, (k % 2 == 0) ? 24'h100000 : 24'h0);
                check("t4_pp_r", hphone_r, (k % 2 == 0) ? 24'h0 : 24'h100000);
            end
        end

        // FIFO full / empty flags in RUN
        cyc(0, 16'h0, 0, 1);
        for (int j = 0; j < 9; j++) cyc(1, 16'($urandom), 0, 0);
        check("t5_full_level", fifo_level, 8);
        check("t5_overrun", overrun, 1);
        cyc(0, 16'h0, 0, 1);
        check("t5_clear", overrun, 0);
        for (int j = 0; j < 9; j++) cyc(0, 16'h0, 1, 0);
        check("t5_empty_l", hphone_l | hphone_r, 0);
        check("t5_underrun", underrun, 1);
        cyc(1, 16'h1234, 1, 0);
        for (int j = 0; j < 8; j++) cyc(1, 16'($urandom), 0, 0);
        cyc(1, 16'h5555, 1, 1);
        check("t5_simul_level", fifo_level, 8);
        check("t5_simul_overrun", overrun, 0);

        // async reset in the middle of a fade-out
        enable = 0;
        begin
            int guard = 0;
            while (!(m_state == FADE_OUT && m_gain == 7) && guard < 40) begin
                frame(16'h2000);
                guard++;
            end
            if (guard >= 40) begin
                n_tests++; n_fail++;
                $display("FAIL t6_reach_gain7: got gain %0d, expected 7", m_gain);
            end
        end
        cyc(1, 16'h0101, 0, 0);
        cyc(1, 16'h0202, 0, 0);
        #2;
        reset_n = 0;
        #1;
        model_reset();
        check("t6_async_state", state, IDLE);
        check("t6_async_out", hphone_l | hphone_r, 0);
        check("t6_async_level", fifo_level, 0);
        #3;
        reset_n = 1;
        enable = 1; mode = 2'b00;
        frame(16'h4000);
        frame(16'h4000);
        check("t6_gain0", hphone_l, 0);
        frame(16'h4000);
        check("t6_gain1", hphone_l, 24'h040000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(119) == 0) enable = ~enable;
            if ($urandom_range(149) == 0) mode = 2'($urandom_range(3));
            cyc($urandom_range(9) < 4, 16'($urandom), $urandom_range(3) == 0,
                $urandom_range(39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
